// File: rtl/polar_encoder_if.sv
// Handshake bundle for polar_encoder: serial info-bit input and serial codeword output.
// Both channels use valid/ready: a beat transfers on a rising edge where valid and ready are both high;
// once raised, valid and its payload hold until that transfer, and ready never depends combinationally on valid.
interface polar_encoder_if;
    logic in_valid;
    logic in_ready;
    logic in_bit;
    logic out_valid;
    logic out_ready;
    logic out_bit;
    logic out_last;

    modport master (
        output in_valid,
        output in_bit,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_bit,
        input  out_last
    );

    modport slave (
        input  in_valid,
        input  in_bit,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_bit,
        output out_last
    );
endinterface

// File: rtl/polar_encoder.sv
// Non-systematic polar encoder: loads K info bits around a frozen mask, runs one butterfly stage per cycle.
// Build option: define POLAR_ENC_BITREV_EN to stream the codeword in bit-reversed index order.
module polar_encoder #(
    parameter int                    LOG2N       = 3,
    parameter int                    K           = 4,
    parameter logic [(2**LOG2N)-1:0] FROZEN_MASK = 8'b0001_0111
) (
    input  logic           clk,
    input  logic           rst,
    polar_encoder_if.slave bus,
    output logic [1:0]     dbg_state_o
);

    localparam int N       = 2 ** LOG2N;
    localparam int CNT_W   = $clog2(K + 1);
    localparam int STAGE_W = (LOG2N > 1) ? $clog2(LOG2N) : 1;

    // Rank of index idx among the non-frozen positions (number of info slots below it).
    function automatic int zeros_below(input int idx);
        int z;
        z = 0;
        for (int j = 0; j < idx; j++) begin
            if (((FROZEN_MASK >> j) & N'(1)) == '0) begin
                z++;
            end
        end
        return z;
    endfunction

    if (K < 1 || K > N || zeros_below(N) != K) begin : g_param_check
        $error("polar_encoder: K must lie in 1..N and equal the number of zero bits in FROZEN_MASK");
    end

    typedef enum logic [1:0] {
        ST_LOAD = 2'd0,
        ST_ENC  = 2'd1,
        ST_OUT  = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [N-1:0]       u_q, u_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [STAGE_W-1:0] stage_q, stage_d;
    logic [LOG2N-1:0]   idx_q, idx_d;
    logic               in_ready_q, in_ready_d;

    logic               accept;
    logic               out_valid_w;
    logic [N-1:0]       info_sel;
    logic [N-1:0]       stage_u [LOG2N];
    logic [LOG2N-1:0]   rd_idx;

    // One-hot write enable: the info slot whose rank equals the number of bits already accepted.
    for (genvar i = 0; i < N; i++) begin : g_info_sel
        if (FROZEN_MASK[i]) begin : g_frozen
            assign info_sel[i] = 1'b0;
        end else begin : g_info
            assign info_sel[i] = (cnt_q == CNT_W'(zeros_below(i)));
        end
    end

    // stage_u[s] is u after applying butterfly stage s; the whole stage resolves in one cycle.
    for (genvar s = 0; s < LOG2N; s++) begin : g_stage
        for (genvar i = 0; i < N; i++) begin : g_bfly
            if (((i >> s) & 1) == 0) begin : g_upper
                assign stage_u[s][i] = u_q[i] ^ u_q[i + (1 << s)];
            end else begin : g_lower
                assign stage_u[s][i] = u_q[i];
            end
        end
    end

`ifdef POLAR_ENC_BITREV_EN
    for (genvar b = 0; b < LOG2N; b++) begin : g_bitrev
        assign rd_idx[b] = idx_q[LOG2N-1-b];
    end
`else
    assign rd_idx = idx_q;
`endif

    assign accept = bus.in_valid & in_ready_q;

    always_comb begin
        state_d = state_q;
        u_d     = u_q;
        cnt_d   = cnt_q;
        stage_d = stage_q;
        idx_d   = idx_q;
        unique case (state_q)
            ST_LOAD: begin
                if (accept) begin
                    u_d   = (u_q & ~info_sel) | (info_sel & {N{bus.in_bit}});
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(K - 1)) begin
                        state_d = ST_ENC;
                        stage_d = '0;
                    end
                end
            end
            ST_ENC: begin
                u_d     = stage_u[stage_q];
                stage_d = stage_q + STAGE_W'(1);
                if (stage_q == STAGE_W'(LOG2N - 1)) begin
                    state_d = ST_OUT;
                    stage_d = '0;
                    idx_d   = '0;
                end
            end
            ST_OUT: begin
                if (bus.out_ready) begin
                    idx_d = idx_q + LOG2N'(1);
                    if (idx_q == '1) begin
                        state_d = ST_LOAD;
                        u_d     = '0;
                        cnt_d   = '0;
                        stage_d = '0;
                        idx_d   = '0;
                    end
                end
            end
            default: begin
                state_d = ST_LOAD;
                u_d     = '0;
                cnt_d   = '0;
                stage_d = '0;
                idx_d   = '0;
            end
        endcase
    end

    // Registered so it stays low through reset and rises on the first edge after release.
    assign in_ready_d = (state_d == ST_LOAD);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_LOAD;
            u_q        <= '0;
            cnt_q      <= '0;
            stage_q    <= '0;
            idx_q      <= '0;
            in_ready_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            u_q        <= u_d;
            cnt_q      <= cnt_d;
            stage_q    <= stage_d;
            idx_q      <= idx_d;
            in_ready_q <= in_ready_d;
        end
    end

    assign out_valid_w   = (state_q == ST_OUT);
    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_w;
    assign bus.out_bit   = out_valid_w & u_q[rd_idx];
    assign bus.out_last  = out_valid_w & (idx_q == '1);
    assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_polar_encoder.sv
// Bench for polar_encoder: generator-matrix reference model, scoreboard queue, per-scenario test tasks.
`timescale 1ns/1ps
module tb_polar_encoder;

    localparam int         LOG2N       = 3;
    localparam int         K           = 4;
    localparam int         N           = 8;
    localparam logic [7:0] FROZEN_MASK = 8'b0001_0111;

    // ---------------- clock / reset ----------------
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] dbg_state;
    int         cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    polar_encoder_if bus();

    polar_encoder #(
        .LOG2N      (LOG2N),
        .K          (K),
        .FROZEN_MASK(FROZEN_MASK)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .dbg_state_o(dbg_state)
    );

    // ---------------- scoreboard state ----------------
    int         checks = 0;
    int         errors = 0;
    int         info_q[$];
    logic [0:0] exp_q[$];
    logic [0:0] got_q[$];
    logic [0:0] last_q[$];
    int         lat_cycles;
    int         first_accept_cyc;
    int         stable_viol;
    int         inready_viol;
    int         valid_in_load;
    bit         timeout_flag;

    // ---------------- reference model ----------------
    function automatic int bitrev(input int v);
        int r;
        r = 0;
        for (int b = 0; b < LOG2N; b++) r = (r << 1) | ((v >> b) & 1);
        return r;
    endfunction

    // x[j] = XOR of u[i] over every i whose set bits contain those of j (row i of F^{(x)n}).
    task automatic load_expected();
        int u[$];
        int k;
        int mask;
        int j;
        int x;
        k = 0;
        mask = int'(FROZEN_MASK);
        exp_q.delete();
        for (int i = 0; i < N; i++) begin
            if (((mask >> i) & 1) != 0) u.push_back(0);
            else begin
                u.push_back(info_q[k]);
                k++;
            end
        end
        for (int e = 0; e < N; e++) begin
            j = e;
`ifdef POLAR_ENC_BITREV_EN
            j = bitrev(e);
`endif
            x = 0;
            for (int i = 0; i < N; i++) if ((i & j) == j) x = x ^ u[i];
            exp_q.push_back(1'(x));
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic random_info();
        info_q.delete();
        for (int k = 0; k < K; k++) info_q.push_back(int'($urandom_range(0, 1)));
    endtask

    task automatic send_info(input bit gaps);
        int n;
        int budget;
        n = 0;
        budget = 0;
        while (n < K && budget < 200) begin
            bus.in_valid  = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            bus.in_bit    = bus.in_valid ? 1'(info_q[n]) : 1'($urandom_range(0, 1));
            bus.out_ready = 1'($urandom_range(0, 1));
            if (bus.out_valid) valid_in_load++;
            if (bus.in_valid && bus.in_ready) begin
                if (n == 0) first_accept_cyc = cyc;
                n++;
            end
            @(negedge clk);
            budget++;
        end
        bus.in_valid = 1'b0;
        if (n < K) timeout_flag = 1'b1;
    endtask

    task automatic collect_out(input int count, input int stall_idx, input bit rand_ready);
        int   n;
        int   since;
        int   budget;
        int   stall_left;
        bit   stalled_done;
        bit   prev_stalled;
        logic prev_bit;
        logic prev_last;
        n = 0;
        since = 1;
        budget = 0;
        stall_left = 0;
        stalled_done = 1'b0;
        prev_stalled = 1'b0;
        prev_bit = 1'b0;
        prev_last = 1'b0;
        lat_cycles = -1;
        while (n < count && budget < 300) begin
            if (bus.in_ready) inready_viol++;
            if (bus.out_valid) begin
                if (lat_cycles < 0) lat_cycles = since;
                if (prev_stalled && (bus.out_bit !== prev_bit || bus.out_last !== prev_last)) stable_viol++;
                if (n == stall_idx && !stalled_done) begin
                    stall_left = 5;
                    stalled_done = 1'b1;
                end
                if (stall_left > 0) begin
                    bus.out_ready = 1'b0;
                    stall_left--;
                end else begin
                    bus.out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
                end
                if (bus.out_ready) begin
                    got_q.push_back(bus.out_bit);
                    last_q.push_back(bus.out_last);
                    n++;
                end
                prev_stalled = !bus.out_ready;
                prev_bit = bus.out_bit;
                prev_last = bus.out_last;
            end else begin
                if (prev_stalled) stable_viol++;
                prev_stalled = 1'b0;
                bus.out_ready = 1'($urandom_range(0, 1));
            end
            @(negedge clk);
            since++;
            budget++;
        end
        bus.out_ready = 1'b0;
        if (n < count) timeout_flag = 1'b1;
    endtask

    task automatic run_frame(input bit gaps, input int stall_idx, input bit rand_ready);
        got_q.delete();
        last_q.delete();
        stable_viol = 0;
        inready_viol = 0;
        valid_in_load = 0;
        timeout_flag = 1'b0;
        send_info(gaps);
        collect_out(N, stall_idx, rand_ready);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        bit stale;
        bus.in_valid = 1'b0;
        bus.in_bit = 1'b0;
        bus.out_ready = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0 || bus.out_bit !== 1'b0 || bus.out_last !== 1'b0) begin
            errors++;
            $display("FAIL reset_values: in_ready=%b out_valid=%b out_bit=%b out_last=%b, required all 0",
                     bus.in_ready, bus.out_valid, bus.out_bit, bus.out_last);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_ready: in_ready=%b, required 1", bus.in_ready);
        end

        // Reset in the middle of the output phase.
        random_info();
        got_q.delete();
        last_q.delete();
        timeout_flag = 1'b0;
        send_info(1'b0);
        collect_out(3, -1, 1'b0);
        checks++;
        if (bus.out_valid !== 1'b1 || timeout_flag) begin
            errors++;
            $display("FAIL reset_mid_out_setup: out_valid=%b timeout=%0d, required out_valid 1", bus.out_valid, timeout_flag);
        end
        rst = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0) begin
                errors++;
                $display("FAIL reset_hold_%0d: out_valid=%b in_ready=%b, required 0/0", c, bus.out_valid, bus.in_ready);
            end
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_release: in_ready=%b out_valid=%b, required 1/0", bus.in_ready, bus.out_valid);
        end
        stale = 1'b0;
        for (int c = 0; c < 6; c++) begin
            if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) stale = 1'b1;
            @(negedge clk);
        end
        checks++;
        if (stale) begin
            errors++;
            $display("FAIL reset_no_stale: stale=1, required out_valid 0 and in_ready 1 while idle");
        end

        random_info();
        load_expected();
        run_frame(1'b0, -1, 1'b0);
        checks++;
        if (timeout_flag || got_q.size() != N) begin
            errors++;
            $display("FAIL reset_next_frame_done: got %0d bits, required %0d", got_q.size(), N);
        end else begin
            for (int k = 0; k < N; k++) begin
                checks++;
                if (got_q[k] !== exp_q[k]) begin
                    errors++;
                    $display("FAIL reset_next_frame_bit%0d: got %b, required %b", k, got_q[k], exp_q[k]);
                end
            end
        end
    endtask

    task automatic test_single_bit();
        int lit[N];
`ifdef POLAR_ENC_BITREV_EN
        lit = '{1, 0, 1, 0, 1, 0, 1, 0};
`else
        lit = '{1, 1, 1, 1, 0, 0, 0, 0};
`endif
        info_q = '{1, 0, 0, 0};
        exp_q.delete();
        for (int k = 0; k < N; k++) exp_q.push_back(1'(lit[k]));
        run_frame(1'b0, -1, 1'b0);
        checks++;
        if (timeout_flag || got_q.size() != N) begin
            errors++;
            $display("FAIL single_bit_done: got %0d bits, required %0d", got_q.size(), N);
        end else begin
            for (int k = 0; k < N; k++) begin
                checks++;
                if (got_q[k] !== exp_q[k] || last_q[k] !== 1'(k == N - 1)) begin
                    errors++;
                    $display("FAIL single_bit_x%0d: bit=%b last=%b, required bit=%b last=%b",
                             k, got_q[k], last_q[k], exp_q[k], (k == N - 1));
                end
            end
        end
    endtask

    task automatic test_all_ones();
        int lit[N];
        lit = '{0, 1, 1, 0, 1, 0, 0, 1};
        info_q = '{1, 1, 1, 1};
        exp_q.delete();
        for (int k = 0; k < N; k++) exp_q.push_back(1'(lit[k]));
        run_frame(1'b0, -1, 1'b0);
        checks++;
        if (lat_cycles != LOG2N + 1) begin
            errors++;
            $display("FAIL all_ones_latency: got %0d cycles, required %0d", lat_cycles, LOG2N + 1);
        end
        checks++;
        if (timeout_flag || got_q.size() != N) begin
            errors++;
            $display("FAIL all_ones_done: got %0d bits, required %0d", got_q.size(), N);
        end else begin
            for (int k = 0; k < N; k++) begin
                checks++;
                if (got_q[k] !== exp_q[k] || last_q[k] !== 1'(k == N - 1)) begin
                    errors++;
                    $display("FAIL all_ones_x%0d: bit=%b last=%b, required bit=%b last=%b",
                             k, got_q[k], last_q[k], exp_q[k], (k == N - 1));
                end
            end
        end
    endtask

    task automatic test_backpressure();
        for (int f = 0; f < 3; f++) begin
            random_info();
            load_expected();
            run_frame(1'b1, 3, 1'b1);
            checks++;
            if (timeout_flag || got_q.size() != N) begin
                errors++;
                $display("FAIL bp_done_f%0d: got %0d bits, required %0d", f, got_q.size(), N);
                continue;
            end
            for (int k = 0; k < N; k++) begin
                checks++;
                if (got_q[k] !== exp_q[k] || last_q[k] !== 1'(k == N - 1)) begin
                    errors++;
                    $display("FAIL bp_f%0d_x%0d: bit=%b last=%b, required bit=%b last=%b",
                             f, k, got_q[k], last_q[k], exp_q[k], (k == N - 1));
                end
            end
            checks++;
            if (stable_viol != 0) begin
                errors++;
                $display("FAIL bp_stable_f%0d: %0d stall violations, required 0", f, stable_viol);
            end
            checks++;
            if (inready_viol != 0 || valid_in_load != 0) begin
                errors++;
                $display("FAIL bp_overlap_f%0d: in_ready high %0d cycles, out_valid in load %0d, required 0/0",
                         f, inready_viol, valid_in_load);
            end
            checks++;
            if (lat_cycles != LOG2N + 1) begin
                errors++;
                $display("FAIL bp_latency_f%0d: got %0d, required %0d", f, lat_cycles, LOG2N + 1);
            end
        end
    endtask

    task automatic test_back_to_back();
        int prev_accept;
        bit bad;
        prev_accept = -1;
        for (int f = 0; f < 20; f++) begin
            random_info();
            load_expected();
            run_frame(1'b0, -1, 1'b0);
            if (timeout_flag || got_q.size() != N) begin
                checks++;
                errors++;
                $display("FAIL b2b_done_f%0d: got %0d bits, required %0d", f, got_q.size(), N);
                continue;
            end
            bad = 1'b0;
            while (exp_q.size() > 0) begin
                if (got_q.pop_front() !== exp_q.pop_front()) bad = 1'b1;
            end
            checks++;
            if (bad) begin
                errors++;
                $display("FAIL b2b_codeword_f%0d: codeword differs from reference model", f);
            end
            if (prev_accept >= 0) begin
                checks++;
                if (first_accept_cyc - prev_accept != K + LOG2N + N) begin
                    errors++;
                    $display("FAIL b2b_period_f%0d: got %0d cycles, required %0d",
                             f, first_accept_cyc - prev_accept, K + LOG2N + N);
                end
            end
            prev_accept = first_accept_cyc;
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        bus.in_valid = 1'b0;
        bus.in_bit = 1'b0;
        bus.out_ready = 1'b0;
        test_reset();
        test_single_bit();
        test_all_ones();
        test_backpressure();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
